ibex_bcp_region_csr: RTL and testbench
======================================

Name: ibex_bcp_region_csr

Overview:
- Holds the BCP region bound table: BCPNumRegions 32-bit entries, organised as start/end pairs.
- Software writes entries through a CSR-style request port. The block drives csr_bcp_addr_o, which feeds the combinational bound checker directly.
- A pair is committed atomically, and only when it is legal, so the checker never sees a half-updated or malformed region.
- A sequencer clears all unlocked entries; it is used on context switch.

Parameters:
- XLEN, 32, datapath width. Tag = XLEN[31:24], address = XLEN[23:0].
- BCPNumRegions, 4, number of entries. Must be even and >= 4. Pair p = entries {2p, 2p+1}.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- csr_req_i  in  1  single-cycle access strobe
- csr_we_i  in  1  1 = write, 0 = read
- csr_idx_i  in  $clog2(BCPNumRegions)  entry index
- csr_wdata_i  in  32  write data
- csr_rdata_o  out  32  read data, registered
- csr_err_o  out  1  one-cycle error pulse, registered
- lock_req_i  in  1  lock strobe (only present with IBEX_BCP_LOCK_EN)
- lock_pair_i  in  $clog2(BCPNumRegions)-1  pair to lock
- clear_req_i  in  1  start the clear sequence
- clear_busy_o  out  1  clear in progress
- clear_done_o  out  1  one-cycle pulse when the clear finishes
- csr_bcp_addr_o  out  32 x BCPNumRegions  committed table
- region_valid_o  out  BCPNumRegions/2  pair committed and legal

Behaviour:

Reset:
- All entries = 0. region_valid_o = 0. csr_rdata_o = 0. csr_err_o = 0.
- clear_busy_o = 0, clear_done_o = 0. Staging register cleared. Locks cleared. FSM = IDLE.

FSM states: IDLE, PEND, CLEAR.

Writes:
- Even index, in IDLE or PEND: data goes to the staging register (stg_data, stg_pair = idx>>1). Next state is PEND. A new even write in PEND overwrites the staging register. The committed table is unchanged.
- Odd index in PEND with idx>>1 == stg_pair: legality check on the staged start S and the written end E.
  - The pair is legal when all hold: S[31:24] == E[31:24]; S[31:30] == 2'b11; S[31:24] != 8'hFF; S[23:0] <= E[23:0] (unsigned).
  - Legal: both entries are written and region_valid_o[p] = 1, visible the cycle after the strobe.
  - Illegal: nothing is written and csr_err_o pulses.
  - In both cases the next state is IDLE.
- Odd index in IDLE, or in PEND with a different pair: csr_err_o pulses. The staging register is kept and the state is unchanged.

Reads:
- csr_rdata_o = committed entry, one cycle after the strobe. The staging register is never visible.
- A read does not affect PEND.

Clear:
- clear_req_i in IDLE or PEND: the staging register is dropped and the state goes to CLEAR. clear_busy_o = 1 from the next cycle.
- One pair per cycle, ascending from pair 0. Unlocked pairs are zeroed and their region_valid_o bit cleared. Locked pairs are skipped but still take one cycle.
- After the last pair: clear_done_o pulses, clear_busy_o = 0, state = IDLE. Duration is BCPNumRegions/2 cycles.
- clear_req_i while already in CLEAR is ignored.

Interactions and conflicts:
- Any CSR write during CLEAR: rejected, csr_err_o pulses. Reads during CLEAR are served.
- csr_req_i and clear_req_i in the same cycle: clear wins; a write is rejected with csr_err_o, a read is served.
- Reset asserted mid-clear or mid-PEND: everything returns to reset values immediately.

Optional Feature:

IBEX_BCP_LOCK_EN
- Defined:
  - lock_req_i sets a sticky lock bit for lock_pair_i. The bit is cleared only by reset.
  - Locking requires region_valid_o[p]; if that bit is 0, csr_err_o pulses and the lock is not set.
  - Any write to an entry of a locked pair pulses csr_err_o and does not change the staging register or the state.
  - Clear skips locked pairs.
- Undefined: lock ports and lock state are absent, and every pair is always writable and clearable.

Test Plan:
- Legal commit: write idx0 = 0xC1000100, then idx1 = 0xC10001FF. Next cycle csr_bcp_addr_o[0..1] hold those values, region_valid_o[0] = 1, csr_err_o = 0.
- Illegal commits: start 0xC2000200 with end 0xC2000100 -> csr_err_o pulse, entries stay 0. Tag mismatch (start 0xC3000000, end 0xC4000010) -> csr_err_o pulse. Tag 0xFF pair -> csr_err_o pulse.
- Ordering errors: write idx1 without a prior idx0 -> csr_err_o. Write idx0, then idx3 -> csr_err_o, still PEND; then idx1 legal -> commits pair 0.
- Clear: commit pairs 0 and 1, assert clear_req_i -> clear_busy_o high for exactly 2 cycles, then clear_done_o pulse, all entries 0, region_valid_o = 0. A write during clear -> csr_err_o.
- Lock (IBEX_BCP_LOCK_EN): commit pair 0, lock it, write idx0 -> csr_err_o. Clear -> pair 0 retained, pair 1 zeroed. Lock an uncommitted pair -> csr_err_o.
- Reset mid-clear: drop rst_ni during cycle 1 of CLEAR -> all outputs at reset values in the same cycle, and the FSM is in IDLE after release.

Source files
------------

// File: rtl/ibex_bcp_region_csr.sv
// BCP region bound table: staged start/end pair commits, clear sequencer, optional
// per-pair locks built in when IBEX_BCP_LOCK_EN is defined.
module ibex_bcp_region_pair #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            commit_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] start_i,
  input  logic [XLEN-1:0] end_i,
  output logic [XLEN-1:0] start_o,
  output logic [XLEN-1:0] end_o,
  output logic            valid_o
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_o <= '0;
      end_o   <= '0;
      valid_o <= 1'b0;
    end else if (clear_i) begin
      start_o <= '0;
      end_o   <= '0;
      valid_o <= 1'b0;
    end else if (commit_i) begin
      start_o <= start_i;
      end_o   <= end_i;
      valid_o <= 1'b1;
    end
  end
endmodule

module ibex_bcp_region_csr #(
  parameter int XLEN          = 32,
  parameter int BCPNumRegions = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  csr_req_i,
  input  logic                                  csr_we_i,
  input  logic [$clog2(BCPNumRegions)-1:0]      csr_idx_i,
  input  logic [XLEN-1:0]                       csr_wdata_i,
  output logic [XLEN-1:0]                       csr_rdata_o,
  output logic                                  csr_err_o,
`ifdef IBEX_BCP_LOCK_EN
  input  logic                                  lock_req_i,
  input  logic [$clog2(BCPNumRegions)-2:0]      lock_pair_i,
`endif
  input  logic                                  clear_req_i,
  output logic                                  clear_busy_o,
  output logic                                  clear_done_o,
  output logic [BCPNumRegions-1:0][XLEN-1:0]    csr_bcp_addr_o,
  output logic [BCPNumRegions/2-1:0]            region_valid_o
);
  localparam int IdxW     = $clog2(BCPNumRegions);
  localparam int PairW    = IdxW - 1;
  localparam int NumPairs = BCPNumRegions / 2;

  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, CLEAR = 2'd2} state_e;
  typedef struct packed {
    logic [PairW-1:0] pair;
    logic [XLEN-1:0]  data;
  } stage_t;

  state_e               state_q, state_d;
  stage_t               stg_q;
  logic [PairW-1:0]     clr_cnt_q;
  logic [NumPairs-1:0]  locked, clr_pair;
  logic [PairW-1:0]     wr_pair;
  logic                 wr, wr_odd, pair_locked, pair_match, pair_close, legal;
  logic                 clr_start, clr_last;
  logic                 stage_en, commit_en, wr_err, lock_err;

  assign wr          = csr_req_i & csr_we_i;
  assign wr_pair     = csr_idx_i[IdxW-1:1];
  assign wr_odd      = csr_idx_i[0];
  assign pair_locked = locked[wr_pair];
  assign pair_match  = (stg_q.pair == wr_pair);
  assign clr_start   = clear_req_i & (state_q != CLEAR);
  assign clr_last    = (state_q == CLEAR) & (clr_cnt_q == PairW'(NumPairs - 1));
  // An odd write that closes the pending pair, whether or not it turns out legal.
  assign pair_close  = wr & wr_odd & ~pair_locked & ~clear_req_i &
                       (state_q == PEND) & pair_match;

  assign legal = (stg_q.data[XLEN-1 -: 8] == csr_wdata_i[XLEN-1 -: 8]) &
                 (stg_q.data[XLEN-1 -: 2] == 2'b11) &
                 (stg_q.data[XLEN-1 -: 8] != 8'hFF) &
                 (stg_q.data[XLEN-9:0] <= csr_wdata_i[XLEN-9:0]);

`ifdef IBEX_BCP_LOCK_EN
  logic [NumPairs-1:0] lock_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                        lock_q <= '0;
    else if (lock_req_i && region_valid_o[lock_pair_i]) lock_q[lock_pair_i] <= 1'b1;
  end
  assign lock_err = lock_req_i & ~region_valid_o[lock_pair_i];
  assign locked   = lock_q;
`else
  assign lock_err = 1'b0;
  assign locked   = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, PEND: begin
        if (clear_req_i)     state_d = CLEAR;
        else if (stage_en)   state_d = PEND;
        else if (pair_close) state_d = IDLE;
      end
      CLEAR:   if (clr_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stage_en  = 1'b0;
    commit_en = 1'b0;
    wr_err    = 1'b0;
    if (wr) begin
      if (state_q == CLEAR || clear_req_i || pair_locked) wr_err = 1'b1;
      else if (!wr_odd)                                   stage_en = 1'b1;
      else if (pair_close)                                begin
        commit_en = legal;
        wr_err    = ~legal;
      end else                                            wr_err = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stg_q        <= '0;
      clr_cnt_q    <= '0;
      csr_rdata_o  <= '0;
      csr_err_o    <= 1'b0;
      clear_done_o <= 1'b0;
    end else begin
      if (clr_start)     stg_q <= '0;
      else if (stage_en) stg_q <= '{pair: wr_pair, data: csr_wdata_i};
      clr_cnt_q    <= (state_q == CLEAR) ? clr_cnt_q + 1'b1 : '0;
      if (csr_req_i && !csr_we_i) csr_rdata_o <= csr_bcp_addr_o[csr_idx_i];
      csr_err_o    <= wr_err | lock_err;
      clear_done_o <= clr_last;
    end
  end

  assign clear_busy_o = (state_q == CLEAR);

  for (genvar p = 0; p < NumPairs; p++) begin : g_pair
    assign clr_pair[p] = (state_q == CLEAR) & (clr_cnt_q == PairW'(p)) & ~locked[p];
    ibex_bcp_region_pair #(.XLEN(XLEN)) u_pair (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .commit_i(commit_en & (stg_q.pair == PairW'(p))),
      .clear_i (clr_pair[p]),
      .start_i (stg_q.data),
      .end_i   (csr_wdata_i),
      .start_o (csr_bcp_addr_o[2*p]),
      .end_o   (csr_bcp_addr_o[2*p+1]),
      .valid_o (region_valid_o[p])
    );
  end
endmodule

// File: tb/tb_ibex_bcp_region_csr.sv
// Randomized bench for ibex_bcp_region_csr against a behavioural table model,
// with directed literal checks for commit, ordering, clear, lock and reset.
module tb_ibex_bcp_region_csr;
  localparam int N  = 4;
  localparam int P  = N / 2;
  localparam int IW = $clog2(N);

  logic                clk = 1'b0, rst_ni = 1'b0;
  logic                req = 1'b0, we = 1'b0, clr = 1'b0;
  logic [IW-1:0]       idx = '0;
  logic [31:0]         wdata = '0;
  logic [31:0]         rdata;
  logic                err, busy, done;
  logic [N-1:0][31:0]  addr;
  logic [P-1:0]        valid;
`ifdef IBEX_BCP_LOCK_EN
  logic                lreq = 1'b0;
  logic [IW-2:0]       lpair = '0;
`endif

  always #5 clk = ~clk;

  ibex_bcp_region_csr #(.XLEN(32), .BCPNumRegions(N)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .csr_req_i(req), .csr_we_i(we), .csr_idx_i(idx),
    .csr_wdata_i(wdata), .csr_rdata_o(rdata), .csr_err_o(err),
`ifdef IBEX_BCP_LOCK_EN
    .lock_req_i(lreq), .lock_pair_i(lpair),
`endif
    .clear_req_i(clr), .clear_busy_o(busy), .clear_done_o(done),
    .csr_bcp_addr_o(addr), .region_valid_o(valid)
  );

  int n_vec = 0, n_mis = 0;

  // Behavioural model: committed table, pending start, clear walk position.
  logic [31:0] m_tbl [N];
  bit          m_vld [P];
  bit          m_lk  [P];
  bit          m_pend, m_clring, m_err, m_done;
  int          m_spair, m_cp;
  logic [31:0] m_sdata, m_rdata;
  logic [7:0]  last_tag = 8'hC0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit legal(logic [31:0] s, logic [31:0] e);
    return s[31:24] == e[31:24] && s[31:30] == 2'b11 && s[31:24] != 8'hFF &&
           s[23:0] <= e[23:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_tbl[i] = '0;
    for (int p = 0; p < P; p++) begin m_vld[p] = 0; m_lk[p] = 0; end
    m_pend = 0; m_clring = 0; m_err = 0; m_done = 0;
    m_spair = 0; m_cp = 0; m_sdata = '0; m_rdata = '0;
  endtask

  task automatic model_step(bit r, bit w, int i, logic [31:0] d, bit c, bit l, int lp);
    bit e = 0, set_lk = 0;
    bit lk_old [P];
    int p = i / 2;
    for (int k = 0; k < P; k++) lk_old[k] = m_lk[k];
    m_done = 0;
    if (r && !w) m_rdata = m_tbl[i];
    if (l) begin
      if (m_vld[lp]) set_lk = 1;
      else e = 1;
    end
    if (m_clring) begin
      if (!lk_old[m_cp]) begin
        m_tbl[2*m_cp] = '0; m_tbl[2*m_cp+1] = '0; m_vld[m_cp] = 0;
      end
      m_cp++;
      if (m_cp == P) begin m_clring = 0; m_done = 1; end
      if (r && w) e = 1;
    end else if (c) begin
      m_clring = 1; m_cp = 0; m_pend = 0;
      if (r && w) e = 1;
    end else if (r && w) begin
      if (lk_old[p]) e = 1;
      else if (i % 2 == 0) begin m_pend = 1; m_spair = p; m_sdata = d; end
      else if (m_pend && m_spair == p) begin
        if (legal(m_sdata, d)) begin
          m_tbl[2*p] = m_sdata; m_tbl[2*p+1] = d; m_vld[p] = 1;
        end else e = 1;
        m_pend = 0;
      end else e = 1;
    end
    if (set_lk) m_lk[lp] = 1;
    m_err = e;
  endtask

  task automatic check_all();
    logic [31:0] ev = '0;
    for (int p = 0; p < P; p++) ev[p] = m_vld[p];
    chk("rdata", rdata, m_rdata);
    chk("err", err, m_err);
    chk("busy", busy, m_clring);
    chk("done", done, m_done);
    chk("valid", valid, ev);
    for (int i = 0; i < N; i++) chk($sformatf("entry%0d", i), addr[i], m_tbl[i]);
  endtask

  // One clock: check outputs of the previous edge, then apply new inputs.
  task automatic cyc(bit r, bit w, int i, logic [31:0] d, bit c, bit l, int lp);
    @(negedge clk);
    check_all();
    req = r; we = w; idx = i[IW-1:0]; wdata = d; clr = c;
`ifdef IBEX_BCP_LOCK_EN
    lreq = l; lpair = lp[IW-2:0];
`endif
    model_step(r, w, i, d, c, l, lp);
  endtask

  task automatic wr(int i, logic [31:0] d); cyc(1, 1, i, d, 0, 0, 0); endtask
  task automatic idle();                    cyc(0, 0, 0, '0, 0, 0, 0); endtask
  task automatic clear();                   cyc(0, 0, 0, '0, 1, 0, 0); endtask

  task automatic rand_cyc();
    bit r, w, c, l;
    int i, lp;
    logic [31:0] d;
    logic [7:0] tag;
    r = ($urandom % 4) != 0; w = ($urandom % 2) != 0; i = $urandom % N;
    if (i % 2 == 0) begin
      tag = ($urandom % 8 == 0) ? 8'($urandom) : 8'($urandom_range(8'hC0, 8'hFF));
      last_tag = tag;
    end else
      tag = ($urandom % 4 != 0) ? last_tag : 8'($urandom);
    d = {tag, 24'($urandom_range(0, 4096))};
    c = ($urandom % 40) == 0;
`ifdef IBEX_BCP_LOCK_EN
    l = ($urandom % 25) == 0;
`else
    l = 0;
`endif
    lp = $urandom % P;
    cyc(r, w, i, d, c, l, lp);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", err, 32'h0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_done", done, 32'h0);
    chk("rst_valid", valid, 32'h0);
    chk("rst_entry0", addr[0], 32'h0);
    @(negedge clk) rst_ni = 1'b1;

    // Legal commit of pair 0
    wr(0, 32'hC1000100); wr(1, 32'hC10001FF); idle();
    chk("commit_e0", addr[0], 32'hC1000100);
    chk("commit_e1", addr[1], 32'hC10001FF);
    chk("commit_v", valid, 32'h1);
    chk("commit_err", err, 32'h0);
    // Illegal pairs: end below start, tag mismatch, tag 0xFF
    wr(2, 32'hC2000200); wr(3, 32'hC2000100); idle();
    chk("ill_order_err", err, 32'h1);
    chk("ill_order_e2", addr[2], 32'h0);
    wr(2, 32'hC3000000); wr(3, 32'hC4000010); idle();
    chk("ill_tag_err", err, 32'h1);
    wr(2, 32'hFF000000); wr(3, 32'hFF000010); idle();
    chk("ill_ff_err", err, 32'h1);
    chk("ill_valid", valid, 32'h1);
    // Ordering errors
    wr(3, 32'hC5000010); idle();
    chk("odd_idle_err", err, 32'h1);
    wr(0, 32'hC5000000); wr(3, 32'hC5000010); idle();
    chk("odd_wrong_pair_err", err, 32'h1);
    wr(1, 32'hC5000010); idle();
    chk("still_pend_e0", addr[0], 32'hC5000000);
    chk("still_pend_err", err, 32'h0);
    // Clear with a write rejected mid-sequence
    wr(2, 32'hC6000000); wr(3, 32'hC6000100);
    clear(); idle();
    chk("clr_busy1", busy, 32'h1);
    wr(0, 32'hC1000000);
    chk("clr_busy2", busy, 32'h1);
    idle();
    chk("clr_busy_end", busy, 32'h0);
    chk("clr_done", done, 32'h1);
    chk("clr_wr_err", err, 32'h1);
    chk("clr_valid", valid, 32'h0);
    chk("clr_e0", addr[0], 32'h0);
    chk("clr_e3", addr[3], 32'h0);
`ifdef IBEX_BCP_LOCK_EN
    wr(0, 32'hC7000000); wr(1, 32'hC7000010);
    cyc(0, 0, 0, '0, 0, 1, 0);
    wr(0, 32'hC9000000); idle();
    chk("lock_wr_err", err, 32'h1);
    cyc(0, 0, 0, '0, 0, 1, 1); idle();
    chk("lock_uncommitted_err", err, 32'h1);
    wr(2, 32'hC6000000); wr(3, 32'hC6000100);
    clear(); idle(); idle(); idle();
    chk("lock_keep_e0", addr[0], 32'hC7000000);
    chk("lock_clr_e2", addr[2], 32'h0);
    chk("lock_valid", valid, 32'h1);
`endif
    // Reset during the first CLEAR cycle
    wr(2, 32'hC8000000); wr(3, 32'hC8000010);
    clear(); idle();
    chk("pre_rst_busy", busy, 32'h1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 32'h0);
    chk("mid_rst_valid", valid, 32'h0);
    chk("mid_rst_e2", addr[2], 32'h0);
    chk("mid_rst_err", err, 32'h0);
    model_reset();
    @(negedge clk) rst_ni = 1'b1;
    wr(0, 32'hCA000000); wr(1, 32'hCA000020); idle();
    chk("post_rst_commit", valid, 32'h1);

    for (int k = 0; k < 3000; k++) rand_cyc();
    idle();
    @(negedge clk);
    check_all();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
